int_root_unit: RTL and testbench

Iterative integer root engine, successor to the fixed 8-bit cube-root block. Computes floor(sqrt(x)) or floor(cbrt(x)) of an unsigned WIDTH-bit operand using digit-by-digit restoring extraction with an internal shift-add multiplier. The root mode is selected per operation. Sits behind a start/busy/valid handshake for use by datapath sequencers in the same lab designs.

---
 rtl/int_root_unit.sv | 154 +++++++++++++++
 tb/tb_int_root_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/int_root_unit.sv
`default_nettype none
// =============================================================================
// Module   : int_root_unit
// Brief    : Iterative floor(sqrt(x)) / floor(cbrt(x)) engine using restoring
//            digit-by-digit extraction and a shift-add multiplier.
//            Optional ROOT_REM_EN adds rem_bo (final residual x - y^k).
// Revision : 1.0 - initial release
// =============================================================================
module int_root_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] x_bi,
  output logic [WIDTH-1:0] y_bo,
  output logic             busy_o,
  output logic             valid_o
`ifdef ROOT_REM_EN
  ,
  output logic [WIDTH-1:0] rem_bo
`endif
);

  localparam int c_yw    = (WIDTH + 1) / 2;
  localparam int c_pw    = 2 * c_yw;
  localparam int c_bw    = 3 * WIDTH + 2;
  localparam int c_sw    = $clog2(WIDTH + 1);
  localparam int c_cw    = $clog2(c_yw + 1);
  localparam int c_n_sq  = (WIDTH + 1) / 2;
  localparam int c_n_cb  = (WIDTH + 2) / 3;
  localparam logic [c_sw-1:0] c_s0_sq = c_sw'(2 * (c_n_sq - 1));
  localparam logic [c_sw-1:0] c_s0_cb = c_sw'(3 * (c_n_cb - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2,
    S_CMP   = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_mode;
  logic [WIDTH-1:0]  r_res;
  logic [c_yw-1:0]   r_y;
  logic [c_sw-1:0]   r_s;
  logic [c_pw-1:0]   r_mcand;
  logic [c_yw-1:0]   r_mplier;
  logic [c_pw-1:0]   r_prod;
  logic [c_cw-1:0]   r_cnt;

  logic [c_yw-1:0]   w_y2;
  logic [c_bw-1:0]   w_base;
  logic [c_bw-1:0]   w_b;
  logic [c_sw-1:0]   w_k;
  logic              w_ge;
  logic [WIDTH-1:0]  w_res_next;
  logic [c_yw-1:0]   w_y_next;

  assign w_y2 = r_y << 1;
  assign w_k  = r_mode ? c_sw'(3) : c_sw'(2);

  // Trial increment is built at full width so an oversized value just loses
  // the compare instead of wrapping into a false match.
  always_comb begin
    w_base = '0;
    if (r_mode) begin
      w_base = c_bw'(r_prod) * c_bw'(3) + c_bw'(1);
    end else begin
      w_base = (c_bw'(r_y) << 1) + c_bw'(1);
    end
  end

  assign w_b        = w_base << r_s;
  assign w_ge       = c_bw'(r_res) >= w_b;
  assign w_res_next = w_ge ? (r_res - w_b[WIDTH-1:0]) : r_res;
  assign w_y_next   = w_ge ? (r_y + c_yw'(1)) : r_y;

  always_ff @(posedge clk_i) begin
    valid_o <= 1'b0;
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_mode   <= 1'b0;
      r_res    <= '0;
      r_y      <= '0;
      r_s      <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      y_bo     <= '0;
      busy_o   <= 1'b0;
`ifdef ROOT_REM_EN
      rem_bo   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_mode  <= mode_i;
            r_res   <= x_bi;
            r_y     <= '0;
            r_s     <= mode_i ? c_s0_cb : c_s0_sq;
            busy_o  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_y <= w_y2;
          if (r_mode) begin
            r_mcand  <= c_pw'(w_y2);
            r_mplier <= w_y2 + c_yw'(1);
            r_prod   <= '0;
            r_cnt    <= '0;
            r_state  <= S_MUL;
          end else begin
            r_state  <= S_CMP;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) begin
            r_prod <= r_prod + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + c_cw'(1);
          if (r_cnt == c_cw'(c_yw - 1)) begin
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_res <= w_res_next;
          r_y   <= w_y_next;
          if (r_s < w_k) begin
            y_bo    <= WIDTH'(w_y_next);
`ifdef ROOT_REM_EN
            rem_bo  <= w_res_next;
`endif
            valid_o <= 1'b1;
            busy_o  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_s     <= r_s - w_k;
            r_state <= S_SHIFT;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_int_root_unit.sv
`default_nettype none
// =============================================================================
// Module   : tb_int_root_unit
// Brief    : Self-checking bench for int_root_unit (WIDTH 8 and 16 instances);
//            checks rem_bo when ROOT_REM_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
module tb_int_root_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        start8 = 1'b0;
  logic        start16 = 1'b0;
  logic [7:0]  x8 = '0;
  logic [15:0] x16 = '0;
  logic [7:0]  y8;
  logic [15:0] y16;
  logic        busy8, busy16, valid8, valid16;
  logic [7:0]  rem8;
  logic [15:0] rem16;
  bit          wide_sel = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_root_unit #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .mode_i(mode), .x_bi(x8),
    .y_bo(y8), .busy_o(busy8), .valid_o(valid8)
`ifdef ROOT_REM_EN
    , .rem_bo(rem8)
`endif
  );

  int_root_unit #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start16), .mode_i(mode), .x_bi(x16),
    .y_bo(y16), .busy_o(busy16), .valid_o(valid16)
`ifdef ROOT_REM_EN
    , .rem_bo(rem16)
`endif
  );

`ifndef ROOT_REM_EN
  assign rem8  = '0;
  assign rem16 = '0;
`endif

  logic [15:0] y_obs, rem_obs;
  logic        busy_obs, valid_obs;
  assign y_obs     = wide_sel ? y16 : {8'h00, y8};
  assign rem_obs   = wide_sel ? rem16 : {8'h00, rem8};
  assign busy_obs  = wide_sel ? busy16 : busy8;
  assign valid_obs = wide_sel ? valid16 : valid8;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: largest y with y^k <= x, found by plain search.
  task automatic ref_root(input int unsigned x, input bit m, output int unsigned y,
                          output int unsigned r);
    longint unsigned t, p;
    t = 0;
    p = 0;
    forever begin
      p = m ? (t + 1) * (t + 1) * (t + 1) : (t + 1) * (t + 1);
      if (p > longint'(x)) break;
      t++;
    end
    y = int'(t);
    r = m ? x - int'(t * t * t) : x - int'(t * t);
  endtask

  function automatic int unsigned latency(input int w, input bit m);
    int n, yw;
    yw = (w + 1) / 2;
    n  = m ? (w + 2) / 3 : (w + 1) / 2;
    return m ? n * (yw + 2) : 2 * n;
  endfunction

  task automatic run(input bit wide, input bit m, input int unsigned x,
                     input bit mid, input bit b2b);
    int unsigned ey, er, el, cyc, nval;
    logic [15:0] yhold;
    ref_root(x, m, ey, er);
    el = latency(wide ? 16 : 8, m);
    @(negedge clk);
    wide_sel = wide;
    mode = m;
    yhold = wide ? y16 : {8'h00, y8};
    if (wide) begin
      x16 = x[15:0];
      start16 = 1'b1;
    end else begin
      x8 = x[7:0];
      start8 = 1'b1;
    end
    @(posedge clk); #1;
    check("accept_busy", busy_obs, 1);
    start8 = 1'b0;
    start16 = 1'b0;
    cyc = 0;
    nval = 0;
    while (busy_obs === 1'b1 && cyc < 300) begin
      @(negedge clk);
      if (mid && cyc == 3) begin
        start8 = !wide;
        start16 = wide;
        x8 = 8'd8;
        x16 = 16'd8;
        mode = ~m;
      end else begin
        start8 = 1'b0;
        start16 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (valid_obs === 1'b1) nval++;
      else check("y_hold", y_obs, yhold);
    end
    start8 = 1'b0;
    start16 = 1'b0;
    check("latency", cyc, el);
    check("valid_count", nval, 1);
    check("valid_at_done", valid_obs, 1);
    check("root", y_obs, ey);
`ifdef ROOT_REM_EN
    check("rem", rem_obs, er);
`endif
    if (!b2b) begin
      @(posedge clk); #1;
      check("valid_pulse", valid_obs, 0);
      check("idle", busy_obs, 0);
      check("y_stable", y_obs, ey);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_y8", y8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_valid8", valid8, 0);
    check("rst_y16", y16, 0);
    check("rst_busy16", busy16, 0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 1, 27, 0, 0);
    run(0, 1, 255, 0, 0);
    run(0, 0, 200, 0, 1);
    run(0, 0, 255, 0, 0);
    run(0, 0, 0, 0, 0);
    run(0, 1, 0, 0, 0);
    run(0, 1, 1, 0, 0);
    run(0, 0, 1, 0, 0);
    run(1, 1, 65535, 0, 0);
    run(1, 0, 65535, 0, 0);
    run(0, 1, 125, 1, 0);

    // Abandon an operation with reset: no result, no pulse.
    @(negedge clk);
    wide_sel = 1'b0;
    mode = 1'b1;
    x8 = 8'd200;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", busy8, 0);
    check("rst_mid_y", y8, 0);
    check("rst_mid_valid", valid8, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("rst_no_valid", valid8, 0);
    end
    run(0, 1, 64, 0, 0);

    for (int i = 0; i < 24; i++) begin
      run(0, 1'($urandom_range(0, 1)), $urandom_range(0, 255), 0,
          1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 10; i++) begin
      run(1, 1'($urandom_range(0, 1)), $urandom_range(0, 65535), 0,
          1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
